// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared constants, state indices, opcode enum and opcode-to-start-state map
package cu_pkg;

  localparam int STATES = 40;
  localparam int OPW    = 5;
  localparam int IDXW   = 6;

  // Microstate indices; each routine occupies a contiguous run of states
  localparam logic [IDXW-1:0] FETCH1  = 6'd0;
  localparam logic [IDXW-1:0] FETCH2  = 6'd1;
  localparam logic [IDXW-1:0] FETCH3  = 6'd2;
  localparam logic [IDXW-1:0] NOP1    = 6'd3;
  localparam logic [IDXW-1:0] MOV1    = 6'd4;
  localparam logic [IDXW-1:0] ALTMOV1 = 6'd5;
  localparam logic [IDXW-1:0] ALTMOV2 = 6'd6;
  localparam logic [IDXW-1:0] LDR1    = 6'd7;
  localparam logic [IDXW-1:0] LDR2    = 6'd8;
  localparam logic [IDXW-1:0] ALTLDR1 = 6'd9;
  localparam logic [IDXW-1:0] ALTLDR2 = 6'd10;
  localparam logic [IDXW-1:0] ALTLDR3 = 6'd11;
  localparam logic [IDXW-1:0] ALTLDR4 = 6'd12;
  localparam logic [IDXW-1:0] STR1    = 6'd13;
  localparam logic [IDXW-1:0] STR2    = 6'd14;
  localparam logic [IDXW-1:0] STR3    = 6'd15;
  localparam logic [IDXW-1:0] STR4    = 6'd16;
  localparam logic [IDXW-1:0] ALTSTR1 = 6'd17;
  localparam logic [IDXW-1:0] ALTSTR2 = 6'd18;
  localparam logic [IDXW-1:0] ALTSTR3 = 6'd19;
  localparam logic [IDXW-1:0] ALTSTR4 = 6'd20;
  localparam logic [IDXW-1:0] CMP1    = 6'd21;
  localparam logic [IDXW-1:0] B1      = 6'd22;
  localparam logic [IDXW-1:0] BGT1    = 6'd23;
  localparam logic [IDXW-1:0] BLT1    = 6'd24;
  localparam logic [IDXW-1:0] BEQ1    = 6'd25;
  localparam logic [IDXW-1:0] ADD1    = 6'd26;
  localparam logic [IDXW-1:0] ADD2    = 6'd27;
  localparam logic [IDXW-1:0] SUB1    = 6'd28;
  localparam logic [IDXW-1:0] SUB2    = 6'd29;
  localparam logic [IDXW-1:0] MUL1    = 6'd30;
  localparam logic [IDXW-1:0] MUL2    = 6'd31;
  localparam logic [IDXW-1:0] LSR1    = 6'd32;
  localparam logic [IDXW-1:0] LSR2    = 6'd33;
  localparam logic [IDXW-1:0] AND1    = 6'd34;
  localparam logic [IDXW-1:0] AND2    = 6'd35;
  localparam logic [IDXW-1:0] OR1     = 6'd36;
  localparam logic [IDXW-1:0] OR2     = 6'd37;
  localparam logic [IDXW-1:0] MVN1    = 6'd38;
  localparam logic [IDXW-1:0] MVN2    = 6'd39;

  localparam logic [IDXW-1:0] LAST_STATE = 6'd39;

  typedef enum logic [OPW-1:0] {
    OP_NOP    = 5'd0,
    OP_MOV    = 5'd1,
    OP_ALTMOV = 5'd2,
    OP_LDR    = 5'd3,
    OP_ALTLDR = 5'd4,
    OP_STR    = 5'd5,
    OP_ALTSTR = 5'd6,
    OP_CMP    = 5'd7,
    OP_B      = 5'd8,
    OP_BGT    = 5'd9,
    OP_BLT    = 5'd10,
    OP_BEQ    = 5'd11,
    OP_ADD    = 5'd12,
    OP_SUB    = 5'd13,
    OP_MUL    = 5'd14,
    OP_LSR    = 5'd15,
    OP_AND    = 5'd16,
    OP_OR     = 5'd17,
    OP_MVN    = 5'd18
  } opcode_t;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
  } start_t;

  // Unmapped opcodes fall through to nop1 so they execute harmlessly
  function automatic start_t start_state(input logic [OPW-1:0] op);
    start_t r;
    r.valid = 1'b1;
    case (op)
      OP_NOP:    r.idx = NOP1;
      OP_MOV:    r.idx = MOV1;
      OP_ALTMOV: r.idx = ALTMOV1;
      OP_LDR:    r.idx = LDR1;
      OP_ALTLDR: r.idx = ALTLDR1;
      OP_STR:    r.idx = STR1;
      OP_ALTSTR: r.idx = ALTSTR1;
      OP_CMP:    r.idx = CMP1;
      OP_B:      r.idx = B1;
      OP_BGT:    r.idx = BGT1;
      OP_BLT:    r.idx = BLT1;
      OP_BEQ:    r.idx = BEQ1;
      OP_ADD:    r.idx = ADD1;
      OP_SUB:    r.idx = SUB1;
      OP_MUL:    r.idx = MUL1;
      OP_LSR:    r.idx = LSR1;
      OP_AND:    r.idx = AND1;
      OP_OR:     r.idx = OR1;
      OP_MVN:    r.idx = MVN1;
      default: begin
        r.valid = 1'b0;
        r.idx   = NOP1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cu_opcode_map.sv
// rtl/cu_opcode_map.sv - combinational opcode to routine start-state lookup
module cu_opcode_map
  import cu_pkg::*;
(
  input  logic [OPW-1:0]  opcode,
  output logic [IDXW-1:0] start_idx,
  output logic            legal
);

  start_t lookup;

  // Thin wrapper so decode logic and benches share one copy of the map
  always_comb begin
    lookup    = start_state(opcode);
    start_idx = lookup.idx;
    legal     = lookup.valid;
  end

endmodule

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - microstep sequencer producing the one-hot CPU_state vector
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              COUNTER_LD,
  input  logic              COUNTER_INC,
  input  logic              COUNTER_CLR,
  input  logic [OPW-1:0]    opcode,
  output logic [STATES-1:0] CPU_state,
  output logic [IDXW-1:0]   state_idx,
  output logic              illegal_op,
  output logic              instr_done,
  output logic [CNTW-1:0]   instr_count
);

  localparam logic [STATES-1:0] ONE_HOT_BASE = {{(STATES-1){1'b0}}, 1'b1};

  logic [IDXW-1:0] state_idx_q, state_idx_d;
  logic            illegal_op_q, illegal_op_d;
  logic            instr_done_q, instr_done_d;
  logic [CNTW-1:0] instr_count_q, instr_count_d;

  logic [IDXW-1:0] map_idx;
  logic            map_legal;

  cu_opcode_map u_map (
    .opcode    (opcode),
    .start_idx (map_idx),
    .legal     (map_legal)
  );

  // Next-state: CLR beats LD beats INC; idle at nop1 returns to fetch1
  always_comb begin
    state_idx_d   = state_idx_q;
    illegal_op_d  = illegal_op_q;
    instr_done_d  = 1'b0;
    instr_count_d = instr_count_q;
    if (en) begin
      if (COUNTER_CLR) begin
        state_idx_d  = FETCH1;
        instr_done_d = (state_idx_q != FETCH1);
      end else if (COUNTER_LD) begin
        state_idx_d = map_idx;
        if (!map_legal) begin
          illegal_op_d = 1'b1;
        end
      end else if (COUNTER_INC) begin
        state_idx_d = (state_idx_q == LAST_STATE) ? FETCH1 : state_idx_q + 6'd1;
      end else if (state_idx_q == NOP1) begin
        state_idx_d  = FETCH1;
        instr_done_d = 1'b1;
      end
      if (instr_done_d) begin
        instr_count_d = instr_count_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  // State registers with synchronous reset overriding enable
  always_ff @(posedge clk) begin
    if (rst) begin
      state_idx_q   <= FETCH1;
      illegal_op_q  <= 1'b0;
      instr_done_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_idx_q   <= state_idx_d;
      illegal_op_q  <= illegal_op_d;
      instr_done_q  <= instr_done_d;
      instr_count_q <= instr_count_d;
    end
  end

  // One-hot view of the registered index
  always_comb begin
    CPU_state = ONE_HOT_BASE << state_idx_q;
  end

  assign state_idx   = state_idx_q;
  assign illegal_op  = illegal_op_q;
  assign instr_done  = instr_done_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// tb/tb_cu_sequencer.sv - table-driven and randomized model-checked bench for cu_sequencer
module tb_cu_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, ld, inc, clr;
  logic [4:0]  opcode;
  logic [39:0] cpu_state, cpu_state_s;
  logic [5:0]  state_idx, state_idx_s;
  logic        illegal_op, illegal_op_s, instr_done, instr_done_s;
  logic [15:0] instr_count;
  logic [3:0]  instr_count_s;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cu_sequencer #(.CNTW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .COUNTER_LD(ld), .COUNTER_INC(inc), .COUNTER_CLR(clr),
    .opcode(opcode), .CPU_state(cpu_state), .state_idx(state_idx), .illegal_op(illegal_op),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  cu_sequencer #(.CNTW(4)) dut_s (
    .clk(clk), .rst(rst), .en(en), .COUNTER_LD(ld), .COUNTER_INC(inc), .COUNTER_CLR(clr),
    .opcode(opcode), .CPU_state(cpu_state_s), .state_idx(state_idx_s), .illegal_op(illegal_op_s),
    .instr_done(instr_done_s), .instr_count(instr_count_s)
  );

  typedef struct {
    logic rst, en, clr, ld, inc;
    int   op;
    int   idx;
    logic done, ill;
    int   cnt;
  } vec_t;

  vec_t vecs[$];

  int start_tbl[19] = '{3, 4, 5, 7, 9, 13, 17, 21, 22, 23, 24, 25, 26, 28, 30, 32, 34, 36, 38};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic add(input logic r, e, c, l, i, input int op, idx, input logic d, il, input int cnt);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.ld = l; v.inc = i; v.op = op;
    v.idx = idx; v.done = d; v.ill = il; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, e, c, l, i, input int op);
    rst = r; en = e; clr = c; ld = l; inc = i; opcode = op[4:0];
  endtask

  task automatic check_all(input string tag, input int idx, input logic d, input logic il, input int cnt);
    logic [63:0] onehot;
    onehot = 64'd1 << idx;
    chk({tag, ".idx"}, 64'(state_idx), 64'(idx));
    chk({tag, ".onehot"}, 64'(cpu_state), onehot);
    chk({tag, ".done"}, 64'(instr_done), 64'(d));
    chk({tag, ".ill"}, 64'(illegal_op), 64'(il));
    chk({tag, ".cnt"}, 64'(instr_count), 64'(cnt & 16'hFFFF));
    chk({tag, ".cnt4"}, 64'(instr_count_s), 64'(cnt & 4'hF));
  endtask

  // Reference model state for randomized phase
  int  m_idx, m_cnt;
  logic m_ill, m_done;

  task automatic model_step(input logic r, e, c, l, i, input int op);
    if (r) begin
      m_idx = 0; m_ill = 0; m_done = 0; m_cnt = 0;
    end else if (!e) begin
      m_done = 0;
    end else begin
      m_done = 0;
      if (c) begin
        if (m_idx != 0) m_done = 1;
        m_idx = 0;
      end else if (l) begin
        if (op < 19) m_idx = start_tbl[op];
        else begin
          m_idx = 3;
          m_ill = 1;
        end
      end else if (i) begin
        m_idx = (m_idx + 1) % 40;
      end else if (m_idx == 3) begin
        m_idx = 0;
        m_done = 1;
      end
      if (m_done) m_cnt = m_cnt + 1;
    end
  endtask

  initial begin
    drive(1, 1, 0, 0, 0, 0);

    //   rst en clr ld inc op   idx done ill cnt
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0,   1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0,   2, 0, 0, 0);
    add(0, 1, 0, 1, 0, 12,  26, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0,   27, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0,   0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 12,  26, 0, 0, 1);
    add(0, 1, 0, 0, 1, 0,   27, 0, 0, 1);
    add(0, 1, 1, 1, 1, 8,   0, 1, 0, 2);
    add(0, 1, 0, 1, 1, 14,  30, 0, 0, 2);
    add(0, 1, 1, 0, 0, 0,   0, 1, 0, 3);
    add(0, 1, 0, 1, 0, 25,  3, 0, 1, 3);
    add(0, 1, 0, 0, 0, 0,   0, 1, 1, 4);
    add(0, 1, 0, 0, 0, 0,   0, 0, 1, 4);
    add(0, 1, 0, 1, 0, 1,   4, 0, 1, 4);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 1, 0, 4, 0, 1, 4);
    add(0, 1, 1, 0, 0, 0,   0, 1, 1, 5);
    add(0, 1, 0, 1, 0, 18,  38, 0, 1, 5);
    add(0, 1, 0, 0, 1, 0,   39, 0, 1, 5);
    add(0, 1, 0, 0, 1, 0,   0, 0, 1, 5);
    add(0, 1, 1, 0, 0, 0,   0, 0, 1, 5);
    add(0, 1, 0, 1, 0, 3,   7, 0, 1, 5);
    add(1, 1, 0, 0, 1, 0,   0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 5,   13, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0,   3, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 1);
    add(0, 1, 0, 1, 0, 0,   3, 0, 0, 1);
    add(0, 0, 1, 1, 1, 30,  3, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 2);

    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].rst, vecs[n].en, vecs[n].clr, vecs[n].ld, vecs[n].inc, vecs[n].op);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", n), vecs[n].idx, vecs[n].done, vecs[n].ill, vecs[n].cnt);
    end

    // Randomized phase: start from reset, follow the behavioural model
    drive(1, 1, 0, 0, 0, 0);
    model_step(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("rnd_reset", m_idx, m_done, m_ill, m_cnt);
    for (int n = 0; n < 3000; n++) begin
      logic r, e, c, l, i;
      int op;
      r  = ($urandom_range(0, 299) == 0);
      e  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 9) == 0);
      l  = ($urandom_range(0, 4) == 0);
      i  = ($urandom_range(0, 9) < 6);
      op = $urandom_range(0, 31);
      drive(r, e, c, l, i, op);
      model_step(r, e, c, l, i, op);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", n), m_idx, m_done, m_ill, m_cnt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
